// File: rtl/ps2_host_tx_if.sv
// Command/status handshake and PS/2 line signals of the PS/2 host transmitter.
// slave is the transmitter's view; master is the surrounding system and line model.
interface ps2_host_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       tx_done;
    logic       tx_err;
    logic       kb_clk_in;
    logic       kb_data_in;
    logic       kb_clk_oe;
    logic       kb_data_oe;

    modport master (
        output tx_start, tx_data, kb_clk_in, kb_data_in,
        input  busy, tx_done, tx_err, kb_clk_oe, kb_data_oe
    );
    modport slave (
        input  tx_start, tx_data, kb_clk_in, kb_data_in,
        output busy, tx_done, tx_err, kb_clk_oe, kb_data_oe
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-keyboard command transmitter: inhibit, request-to-send, 8-bit frame
// with odd parity and stop, keyboard acknowledge check, and a transfer timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave bus
);
    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       data_sync_q, data_sync_d;
    logic [7:0]       byte_q, byte_d;
    logic             par_q, par_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic             drive_low_q, drive_low_d;
    logic             ack_err_q, ack_err_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             kb_fall;
    logic             tmo_active;

    // Frame bit at a given index: 0..7 data LSB first, 8 parity, 9 stop.
    function automatic logic frame_bit(input logic [7:0] b, input logic p,
                                       input logic [3:0] idx);
        if (idx < 4'd8)       return b[idx[2:0]];
        else if (idx == 4'd8) return p;
        else                  return 1'b1;
    endfunction

    // clk_sync_q[2] is the previous synchronized level, used for edge detection.
    assign kb_fall    = clk_sync_q[2] & ~clk_sync_q[1];
    assign tmo_active = (state_q == REQ) || (state_q == SHIFT) ||
                        (state_q == ACK) || (state_q == WAIT_IDLE);

    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], bus.kb_clk_in};
        data_sync_d = {data_sync_q[0], bus.kb_data_in};
        state_d     = state_q;
        byte_d      = byte_q;
        par_d       = par_q;
        bit_idx_d   = bit_idx_q;
        drive_low_d = drive_low_q;
        ack_err_d   = ack_err_q;
        inh_cnt_d   = inh_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (tmo_active) begin
            tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
        end

        if (tmo_active && (tmo_cnt_q >= TMO_LAST)) begin
            state_d     = IDLE;
            done_d      = 1'b1;
            err_d       = 1'b1;
            tmo_cnt_d   = '0;
            bit_idx_d   = '0;
            drive_low_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.tx_start) begin
                        byte_d    = bus.tx_data;
                        par_d     = ~^bus.tx_data;
                        inh_cnt_d = '0;
                        state_d   = INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt_q == INH_LAST) begin
                        inh_cnt_d = '0;
                        tmo_cnt_d = '0;
                        state_d   = REQ;
                    end else begin
                        inh_cnt_d = inh_cnt_q + 1'b1;
                    end
                end
                REQ: begin
                    if (kb_fall) begin
                        bit_idx_d   = '0;
                        drive_low_d = ~byte_q[0];
                        state_d     = SHIFT;
                    end
                end
                SHIFT: begin
                    if (kb_fall) begin
                        bit_idx_d   = bit_idx_q + 4'd1;
                        drive_low_d = ~frame_bit(byte_q, par_q, bit_idx_q + 4'd1);
                        if (bit_idx_q == 4'd8) state_d = ACK;
                    end
                end
                ACK: begin
                    if (kb_fall) begin
                        ack_err_d = data_sync_q[1];
                        state_d   = WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_sync_q[1] && data_sync_q[1]) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        err_d       = ack_err_q;
                        bit_idx_d   = '0;
                        tmo_cnt_d   = '0;
                        drive_low_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
            byte_q      <= '0;
            par_q       <= 1'b0;
            bit_idx_q   <= '0;
            drive_low_q <= 1'b0;
            ack_err_q   <= 1'b0;
            inh_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            byte_q      <= byte_d;
            par_q       <= par_d;
            bit_idx_q   <= bit_idx_d;
            drive_low_q <= drive_low_d;
            ack_err_q   <= ack_err_d;
            inh_cnt_q   <= inh_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Line drivers decode straight from state so an async reset releases them at once.
    assign bus.kb_clk_oe  = (state_q == INHIBIT);
    assign bus.kb_data_oe = ((state_q == INHIBIT) && (inh_cnt_q == INH_LAST)) ||
                            (state_q == REQ) ||
                            ((state_q == SHIFT) && drive_low_q);
    assign bus.busy       = (state_q != IDLE);
    assign bus.tx_done    = done_q;
    assign bus.tx_err     = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a keyboard line model clocks frames and checks them
// against an arithmetic frame model, plus timeout, busy and reset scenarios.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH  = 50;
    localparam int TMO  = 1000;
    localparam int HALF = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic kbd_clk = 1'b1;
    logic kbd_data = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ps2_host_tx_if bus();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Open-drain wired-AND of keyboard and host drivers.
    assign bus.kb_clk_in  = kbd_clk & ~bus.kb_clk_oe;
    assign bus.kb_data_in = kbd_data & ~bus.kb_data_oe;

    // Expected line levels after falling edges 1..10: data LSB first, odd parity, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        int ones;
        logic [7:0] t;
        ones = 0;
        t = d;
        repeat (8) begin
            ones += int'(t[0]);
            t = t >> 1;
        end
        return {1'b1, (ones % 2 == 0), d};
    endfunction

    task automatic start_tx(input logic [7:0] d, output int n_inh, output int first_dat,
                            output logic busy1);
        @(negedge clk);
        bus.tx_start = 1'b1;
        bus.tx_data  = d;
        @(negedge clk);
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'($urandom);
        busy1 = bus.busy;
        n_inh = 0;
        first_dat = -1;
        while (bus.kb_clk_oe && n_inh < 5 * INH) begin
            if (bus.kb_data_oe && first_dat < 0) first_dat = n_inh;
            n_inh++;
            @(negedge clk);
        end
    endtask

    task automatic kbd_frame(input bit do_ack, input int n_edges,
                             output logic [9:0] got, output bit ok);
        int w;
        got = '0;
        ok = 1'b1;
        w = 0;
        while (!(bus.kb_data_oe && !bus.kb_clk_oe) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) begin
            ok = 1'b0;
            return;
        end
        repeat (HALF) @(negedge clk);
        for (int e = 1; e <= n_edges; e++) begin
            if (e == 11 && do_ack) kbd_data = 1'b0;
            repeat (5) @(negedge clk);
            kbd_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            kbd_clk = 1'b1;
            if (e <= 10) got = {bus.kb_data_in, got[9:1]};
            if (e == 11) begin
                kbd_data = 1'b1;
                break;
            end
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic wait_done(input int limit, output bit seen, output logic err,
                             output logic bsy, output int cyc);
        cyc = 0;
        seen = 1'b0;
        while (cyc < limit) begin
            if (bus.tx_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        err = bus.tx_err;
        bsy = bus.busy;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.kb_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b want 0", bus.kb_clk_oe); end
        checks++; if (bus.kb_data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b want 0", bus.kb_data_oe); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if ({bus.tx_done, bus.tx_err} !== 2'b00) begin errors++; $display("FAIL reset_done_err: got %b want 00", {bus.tx_done, bus.tx_err}); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_frame(input logic [7:0] d, input bit do_ack);
        int n, f, cyc;
        logic b1, err, bsy;
        logic [9:0] got;
        bit ok, seen;
        start_tx(d, n, f, b1);
        kbd_frame(do_ack, 11, got, ok);
        checks++; if (!ok || got !== model_frame(d)) begin errors++; $display("FAIL frame_bits[%h]: got %b want %b (req_seen=%0d)", d, got, model_frame(d), ok); end
        wait_done(200, seen, err, bsy, cyc);
        checks++; if (!seen) begin errors++; $display("FAIL frame_done[%h]: got 0 want 1", d); end
        checks++; if (err !== ~do_ack) begin errors++; $display("FAIL frame_err[%h]: got %b want %b", d, err, ~do_ack); end
        checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL frame_busy_end[%h]: got %b want 0", d, bsy); end
        @(negedge clk);
        checks++; if (bus.tx_done !== 1'b0) begin errors++; $display("FAIL frame_done_pulse[%h]: got %b want 0", d, bus.tx_done); end
    endtask

    task automatic test_inhibit;
        int n, f, cyc;
        logic b1, err, bsy;
        logic [7:0] d;
        logic [9:0] got;
        bit ok, seen;
        d = 8'($urandom);
        start_tx(d, n, f, b1);
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL inhibit_busy: got %b want 1", b1); end
        checks++; if (n !== INH) begin errors++; $display("FAIL inhibit_len: got %0d want %0d", n, INH); end
        checks++; if (f !== INH - 1) begin errors++; $display("FAIL inhibit_data_rise: got %0d want %0d", f, INH - 1); end
        checks++; if (bus.kb_data_oe !== 1'b1) begin errors++; $display("FAIL req_data_oe: got %b want 1", bus.kb_data_oe); end
        kbd_frame(1'b1, 11, got, ok);
        checks++; if (!ok || got !== model_frame(d)) begin errors++; $display("FAIL inhibit_frame: got %b want %b", got, model_frame(d)); end
        wait_done(200, seen, err, bsy, cyc);
        checks++; if (!seen || err !== 1'b0) begin errors++; $display("FAIL inhibit_done: got done=%0d err=%b want 1 0", seen, err); end
    endtask

    task automatic test_timeout;
        int n, f, cyc;
        logic b1, err, bsy;
        bit seen;
        start_tx(8'($urandom), n, f, b1);
        wait_done(TMO + 100, seen, err, bsy, cyc);
        checks++; if (!seen || cyc !== TMO) begin errors++; $display("FAIL timeout_cycles: got %0d (seen=%0d) want %0d", cyc, seen, TMO); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", err); end
        checks++; if ({bus.kb_clk_oe, bus.kb_data_oe} !== 2'b00) begin errors++; $display("FAIL timeout_lines: got %b want 00", {bus.kb_clk_oe, bus.kb_data_oe}); end
        checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b want 0", bsy); end
    endtask

    task automatic test_busy_ignore;
        int cyc, busy_cnt;
        logic err, bsy;
        logic [7:0] d;
        logic [9:0] got;
        bit ok, seen;
        d = 8'($urandom_range(0, 254));
        @(negedge clk);
        bus.tx_start = 1'b1;
        bus.tx_data  = d;
        @(negedge clk);
        bus.tx_start = 1'b0;
        repeat (10) @(negedge clk);
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'hFF;
        @(negedge clk);
        bus.tx_start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b want 1", bus.busy); end
        kbd_frame(1'b1, 11, got, ok);
        checks++; if (!ok || got !== model_frame(d)) begin errors++; $display("FAIL ignore_frame: got %b want %b", got, model_frame(d)); end
        wait_done(200, seen, err, bsy, cyc);
        checks++; if (!seen || err !== 1'b0) begin errors++; $display("FAIL ignore_done: got done=%0d err=%b want 1 0", seen, err); end
        busy_cnt = 0;
        repeat (INH + 20) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
        end
        checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL ignore_no_restart: got %0d busy cycles want 0", busy_cnt); end
    endtask

    task automatic test_reset_mid;
        int n, f, done_cnt;
        logic b1;
        logic [9:0] got;
        bit ok;
        start_tx(8'($urandom), n, f, b1);
        kbd_frame(1'b1, 4, got, ok);
        checks++; if (!ok || bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b want 1", bus.busy); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({bus.kb_clk_oe, bus.kb_data_oe} !== 2'b00) begin errors++; $display("FAIL midrst_lines: got %b want 00", {bus.kb_clk_oe, bus.kb_data_oe}); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        done_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.tx_done) done_cnt++;
        end
        rst = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (bus.tx_done) done_cnt++;
        end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt); end
        test_frame(8'($urandom), 1'b1);
    endtask

    initial begin
        test_reset();
        test_inhibit();
        test_frame(8'hED, 1'b1);
        test_frame(8'h00, 1'b0);
        for (int i = 0; i < 6; i++) test_frame(8'($urandom), 1'($urandom));
        test_timeout();
        test_busy_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
